// File: rtl/ssd1306_spi_decoder.sv
// SSD1306 4-wire SPI receiver: synchronises the SPI pins into the pixel clock,
// assembles bytes, decodes addressing commands and emits framebuffer writes.
module ssd1306_spi_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int COLS        = 128,
    parameter int PAGES       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wclk,
    input  logic       din,
    input  logic       dc,
    input  logic       cs,
    output logic       fb_we,
    output logic [9:0] fb_addr,
    output logic [7:0] fb_data,
    output logic       display_on,
    output logic       invert
);

    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);

    typedef enum logic [2:0] {
        IDLE,
        ARG_MODE,
        ARG_CS,
        ARG_CE,
        ARG_PS,
        ARG_PE,
        SKIP1
    } state_t;

    logic [SYNC_STAGES-1:0] wclk_sync, din_sync, dc_sync, cs_sync;
    logic                   wclk_prev;
    logic                   wclk_s, din_s, dc_s, cs_s;

    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    state_t        state, state_next;
    logic [1:0]    mode;
    logic [CW-1:0] col, col_start, col_end;
    logic [PW-1:0] page, page_start, page_end;

    logic       wclk_rise, shift_in, byte_done, data_done, cmd_done;
    logic       skip_cmd;
    logic [7:0] byte_val;
    logic [9:0] addr_cur;

    // cs synchroniser resets to the deselected level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wclk_sync <= '0;
            din_sync  <= '0;
            dc_sync   <= '0;
            cs_sync   <= '1;
            wclk_prev <= 1'b0;
        end else begin
            wclk_sync <= {wclk_sync[SYNC_STAGES-2:0], wclk};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            wclk_prev <= wclk_s;
        end
    end

    assign wclk_s = wclk_sync[SYNC_STAGES-1];
    assign din_s  = din_sync[SYNC_STAGES-1];
    assign dc_s   = dc_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];

    assign wclk_rise = wclk_s & ~wclk_prev;
    assign shift_in  = wclk_rise & ~cs_s;
    assign byte_done = shift_in & (bit_cnt == 3'd7);
    assign byte_val  = {shreg[6:0], din_s};
    assign data_done = byte_done & dc_s;
    assign cmd_done  = byte_done & ~dc_s;
    assign addr_cur  = 10'(page) * 10'(COLS) + 10'(col);

    always_comb begin
        case (byte_val)
            8'h81, 8'h8D, 8'hA8, 8'hD3,
            8'hD5, 8'hD9, 8'hDA, 8'hDB: skip_cmd = 1'b1;
            default:                    skip_cmd = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (cs_s) begin
            bit_cnt <= '0;
        end else if (shift_in) begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= byte_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (cs_s) begin
            state_next = IDLE;
        end else if (cmd_done) begin
            case (state)
                IDLE: begin
                    if (byte_val == 8'h20)      state_next = ARG_MODE;
                    else if (byte_val == 8'h21) state_next = ARG_CS;
                    else if (byte_val == 8'h22) state_next = ARG_PS;
                    else if (skip_cmd)          state_next = SKIP1;
                end
                ARG_CS:  state_next = ARG_CE;
                ARG_PS:  state_next = ARG_PE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            display_on <= 1'b0;
            invert     <= 1'b0;
            mode       <= 2'd2;
            col        <= '0;
            page       <= '0;
            col_start  <= '0;
            col_end    <= CW'(COLS - 1);
            page_start <= '0;
            page_end   <= PW'(PAGES - 1);
        end else begin
            fb_we <= 1'b0;
            if (data_done) begin
                fb_we   <= 1'b1;
                fb_addr <= addr_cur;
                fb_data <= byte_val;
                case (mode)
                    2'd0: begin
                        if (col == col_end) begin
                            col  <= col_start;
                            page <= (page == page_end) ? page_start : page + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                    2'd1: begin
                        if (page == page_end) begin
                            page <= page_start;
                            col  <= (col == col_end) ? col_start : col + 1'b1;
                        end else begin
                            page <= page + 1'b1;
                        end
                    end
                    default: col <= (col == CW'(COLS - 1)) ? '0 : col + 1'b1;
                endcase
            end else if (cmd_done) begin
                case (state)
                    IDLE: begin
                        if (byte_val[7:4] == 4'h0)
                            col[3:0] <= byte_val[3:0];
                        else if (byte_val[7:3] == 5'b00010)
                            col[CW-1:4] <= byte_val[CW-5:0];
                        else if (byte_val[7:3] == 5'b10110)
                            page <= byte_val[PW-1:0];
                        else if (byte_val == 8'hAE || byte_val == 8'hAF)
                            display_on <= byte_val[0];
                        else if (byte_val == 8'hA6 || byte_val == 8'hA7)
                            invert <= byte_val[0];
                    end
                    ARG_MODE: if (byte_val[1:0] != 2'd3) mode <= byte_val[1:0];
                    ARG_CS: begin
                        col_start <= byte_val[CW-1:0];
                        col       <= byte_val[CW-1:0];
                    end
                    ARG_CE: col_end <= byte_val[CW-1:0];
                    ARG_PS: begin
                        page_start <= byte_val[PW-1:0];
                        page       <= byte_val[PW-1:0];
                    end
                    ARG_PE:  page_end <= byte_val[PW-1:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/ssd1306_spi_decoder.md
Name: ssd1306_spi_decoder

Overview:
- Upstream stage of the VGA framebuffer. Receives the raw SSD1306 4-wire SPI stream (wclk, din, dc, cs) in the 25.125 MHz pixel clock domain.
- Assembles bytes and interprets the SSD1306 addressing commands.
- Emits one byte-wide framebuffer write per display-data byte at the correct GDDRAM address (page*128 + column), honouring horizontal, vertical and page addressing modes.
- Also decodes display on/off and normal/inverse for the scan-out stage.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each SPI input before use; minimum 2.
- COLS, 128, display columns; column pointer width is clog2(COLS).
- PAGES, 8, display pages of 8 rows each; page pointer width is clog2(PAGES).

Ports:
- clk  in  1  pixel clock (PLL output); all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- wclk  in  1  SPI clock, asynchronous to clk; data sampled on its rising edge.
- din  in  1  SPI data, MSB first.
- dc  in  1  1 = display data, 0 = command; sampled with the 8th bit of each byte.
- cs  in  1  active-low chip select.
- fb_we  out  1  one-clk write strobe to the framebuffer.
- fb_addr  out  10  byte address, page*COLS + column.
- fb_data  out  8  data byte; bit 0 is the top row of the page.
- display_on  out  1  1 after 0xAF, 0 after 0xAE.
- invert  out  1  1 after 0xA7, 0 after 0xA6.

Behaviour:
- Reset values (rst_n=0 at a clk edge): fb_we=0, fb_addr=0, fb_data=0, display_on=0, invert=0.
  - Internal state: bit count 0, parser IDLE, mode=2 (page), col=0, page=0, col_start=0, col_end=127, page_start=0, page_end=7.
- Input capture:
  - wclk, din, dc, cs each pass through SYNC_STAGES flops.
  - A wclk rising edge is detected as synced 0 -> 1.
  - wclk high and low times must each be at least 2 clk periods; faster input is out of spec.
- Byte assembly:
  - On each detected edge with synced cs=0, shift din into an 8-bit register, MSB first.
  - The 8th bit completes the byte; dc is taken from that same edge.
  - Synced cs=1 clears the bit count (a partial byte is discarded) and returns the parser to IDLE.
  - Address pointers and mode are kept across cs deassertion.
- Data byte (dc=1):
  - fb_we is high for exactly one clk, in the cycle after the completing edge is detected.
  - fb_addr = page*128 + col and fb_data = byte, both valid while fb_we=1 and held afterwards.
  - Pointers advance in that same cycle:
    - mode 0 (horizontal): if col==col_end then col<=col_start and page<=(page==page_end ? page_start : page+1); else col+1.
    - mode 1 (vertical): if page==page_end then page<=page_start and col<=(col==col_end ? col_start : col+1); else page+1.
    - mode 2 (page): col<=(col==127 ? 0 : col+1); page unchanged.
- Command parser (dc=0), states IDLE, ARG_MODE, ARG_CS, ARG_CE, ARG_PS, ARG_PE, SKIP1:
  - IDLE, 0x20 -> ARG_MODE. The argument's bits[1:0] set mode; value 3 is ignored. -> IDLE.
  - IDLE, 0x21 -> ARG_CS: col_start = col = arg&0x7F; -> ARG_CE: col_end = arg&0x7F; -> IDLE.
  - IDLE, 0x22 -> ARG_PS: page_start = page = arg&7; -> ARG_PE: page_end = arg&7; -> IDLE.
  - 0x00-0x0F: col[3:0] = nibble. 0x10-0x17: col[6:4] = nibble[2:0]. 0xB0-0xB7: page = low 3 bits. These three take effect in every mode.
  - 0xAE/0xAF set display_on; 0xA6/0xA7 set invert.
  - 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB -> SKIP1: the next command byte is consumed without effect. -> IDLE.
  - All other command bytes are ignored; parser stays IDLE.
- A data byte arriving while an argument is pending is written normally; the parser state is unchanged.
- A command never asserts fb_we.
- Edge cases:
  - col_end < col_start or page_end < page_start: equality comparisons still apply; the pointer runs up to its maximum value and wraps to 0 via natural overflow.
  - rst_n mid-byte or mid-argument restores all reset values on that edge; the first later edge is treated as bit 7 of a fresh byte.

Test Plan:
- Reset, then cs=0, dc=1, send 0xA5 -> one fb_we pulse with fb_addr=0 and fb_data=0xA5; the next byte goes to fb_addr=1.
- Send 0x20 0x00, 0x21 0x02 0x03, 0x22 0x01 0x02, then 5 data bytes -> fb_addr sequence 130, 131, 258, 259, 130.
- Send 0x20 0x01, 0x21 0x00 0x7F, 0x22 0x06 0x07, then 3 data bytes -> fb_addr sequence 768, 896, 769.
- Page mode: send 0xB3 0x0F 0x17, then 2 data bytes -> fb_addr 511, then 384 (col wraps, page stays 3).
- Send 4 bits, raise cs, lower cs, send 0x81 0xAF (cmd) then 0xAF (cmd) -> partial byte dropped; contrast argument skipped; display_on=1 only after the second 0xAF; no fb_we.
- Assert rst_n=0 after 0x21 0x05 -> all outputs are 0; after release a data byte writes fb_addr=0.
